// File: rtl/plab5_mcore_mem_net_req_inject.sv
// Domain-aware injection queue feeding the request network port.
// Control and data halves of each message are stored in separate arrays.
module plab5_mcore_mem_net_req_inject #(
  parameter int unsigned p_ctrl_nbits  = 56,
  parameter int unsigned p_data_nbits  = 32,
  parameter int unsigned p_num_entries = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic                              in_domain,
  input  logic [p_ctrl_nbits-1:0]           in_msg_control,
  input  logic [p_data_nbits-1:0]           in_msg_data,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic                              out_domain,
  output logic [p_ctrl_nbits-1:0]           out_msg_control,
  output logic [p_data_nbits-1:0]           out_msg_data,
  output logic [$clog2(p_num_entries):0]    count
);

  localparam int unsigned AW = $clog2(p_num_entries);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(p_num_entries);

  logic [p_ctrl_nbits-1:0] ctrl_q [p_num_entries];
  logic [p_data_nbits-1:0] data_q [p_num_entries];
  logic [AW-1:0]           enq_ptr;
  logic [AW-1:0]           deq_ptr;
  logic                    cur_domain;
  logic                    enq;
  logic                    deq;

  // A domain change is only admitted into an empty queue, so the queue
  // never mixes domains; a full queue never admits, even while draining.
  always_comb begin
    in_rdy          = (count < FULL) && ((count == '0) || (in_domain == cur_domain));
    out_val         = (count != '0);
    out_domain      = cur_domain;
    out_msg_control = '0;
    out_msg_data    = '0;
    if (out_val) begin
      out_msg_control = ctrl_q[deq_ptr];
      out_msg_data    = data_q[deq_ptr];
    end
  end

  assign enq = in_val  && in_rdy;
  assign deq = out_val && out_rdy;

  // Depth is a power of 2, so natural pointer overflow is the wrap to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      cur_domain <= 1'b0;
      for (int unsigned i = 0; i < p_num_entries; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Scrub the freed slot; an enqueue never targets it in the same cycle.
      if (deq) begin
        ctrl_q[deq_ptr] <= '0;
        data_q[deq_ptr] <= '0;
        deq_ptr         <= deq_ptr + AW'(1);
      end
      if (enq) begin
        ctrl_q[enq_ptr] <= in_msg_control;
        data_q[enq_ptr] <= in_msg_data;
        enq_ptr         <= enq_ptr + AW'(1);
        cur_domain      <= in_domain;
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_net_req_inject.sv
// Directed bench for the request injection queue (default parameters, depth 4).
module tb_plab5_mcore_mem_net_req_inject;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic        in_domain;
  logic [55:0] in_msg_control;
  logic [31:0] in_msg_data;
  logic        out_val;
  logic        out_rdy;
  logic        out_domain;
  logic [55:0] out_msg_control;
  logic [31:0] out_msg_data;
  logic [2:0]  count;

  int checks;
  int failures;

  plab5_mcore_mem_net_req_inject #(
    .p_ctrl_nbits  (56),
    .p_data_nbits  (32),
    .p_num_entries (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .in_domain       (in_domain),
    .in_msg_control  (in_msg_control),
    .in_msg_data     (in_msg_data),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .out_domain      (out_domain),
    .out_msg_control (out_msg_control),
    .out_msg_data    (out_msg_data),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] d, input logic [55:0] c);
    chk({tag, "_val"},  64'(out_val), 64'd1);
    chk({tag, "_data"}, 64'(out_msg_data), 64'(d));
    chk({tag, "_ctrl"}, 64'(out_msg_control), 64'(c));
  endtask

  task automatic drive(input logic v, input logic dom, input logic [55:0] c, input logic [31:0] d);
    in_val         = v;
    in_domain      = dom;
    in_msg_control = c;
    in_msg_data    = d;
    #1;
  endtask

  logic [55:0] hold_ctrl;
  logic [31:0] hold_data;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    out_rdy = 1'b0;
    drive(1'b0, 1'b0, '0, '0);

    // reset state
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_rdy_d0", 64'(in_rdy), 64'd1);
    chk("rst_out_domain", 64'(out_domain), 64'd0);
    chk("rst_data", 64'(out_msg_data), 64'd0);
    chk("rst_ctrl", 64'(out_msg_control), 64'd0);
    drive(1'b1, 1'b1, 56'h5, 32'hDEAD);
    chk("rst_in_rdy_d1", 64'(in_rdy), 64'd1);
    tick();
    chk("rst_no_enq_count", 64'(count), 64'd0);
    chk("rst_no_enq_val", 64'(out_val), 64'd0);
    reset = 1'b0;

    // basic flow, with no same-cycle bypass
    drive(1'b1, 1'b0, 56'h1, 32'hA5A5A5A5);
    chk("basic_empty_out_val", 64'(out_val), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    head("basic_head", 32'hA5A5A5A5, 56'h1);
    chk("basic_count1", 64'(count), 64'd1);
    out_rdy = 1'b1;
    tick();
    chk("basic_drained_val", 64'(out_val), 64'd0);
    chk("basic_drained_data", 64'(out_msg_data), 64'd0);
    chk("basic_drained_ctrl", 64'(out_msg_control), 64'd0);
    chk("basic_drained_count", 64'(count), 64'd0);
    out_rdy = 1'b0;

    // fill to full
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 56'(32'h100 + i), 32'(i));
      tick();
    end
    chk("fill_count4", 64'(count), 64'd4);
    chk("fill_in_rdy0", 64'(in_rdy), 64'd0);
    head("fill_head1", 32'd1, 56'h101);

    // stream with wrap; first cycle is full with a simultaneous dequeue
    out_rdy = 1'b1;
    drive(1'b1, 1'b0, 56'h105, 32'd5);
    chk("full_deq_in_rdy0", 64'(in_rdy), 64'd0);
    tick();
    chk("full_deq_count3", 64'(count), 64'd3);
    head("stream_h2", 32'd2, 56'h102);
    chk("stream_in_rdy1", 64'(in_rdy), 64'd1);
    tick();
    chk("stream_count_same", 64'(count), 64'd3);
    drive(1'b1, 1'b0, 56'h106, 32'd6);
    head("stream_h3", 32'd3, 56'h103);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    head("stream_h4", 32'd4, 56'h104);
    chk("stream_count3b", 64'(count), 64'd3);
    tick();
    head("stream_h5", 32'd5, 56'h105);
    tick();
    head("stream_h6", 32'd6, 56'h106);
    chk("stream_count1", 64'(count), 64'd1);
    tick();
    chk("stream_empty_val", 64'(out_val), 64'd0);
    chk("stream_empty_data", 64'(out_msg_data), 64'd0);
    out_rdy = 1'b0;

    // domain switch, with backpressure while stalled
    drive(1'b1, 1'b0, 56'h21, 32'h11);
    tick();
    drive(1'b1, 1'b0, 56'h22, 32'h22);
    tick();
    drive(1'b1, 1'b1, 56'h33, 32'h33);
    chk("dom_stall_in_rdy", 64'(in_rdy), 64'd0);
    hold_ctrl = out_msg_control;
    hold_data = out_msg_data;
    chk("bp_first_data", 64'(hold_data), 64'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ctrl_hold", 64'(out_msg_control), 64'(hold_ctrl));
      chk("bp_data_hold", 64'(out_msg_data), 64'(hold_data));
      chk("bp_count2", 64'(count), 64'd2);
      chk("bp_in_rdy0", 64'(in_rdy), 64'd0);
    end
    out_rdy = 1'b1;
    tick();
    head("dom_h22", 32'h22, 56'h22);
    chk("dom_count1_in_rdy0", 64'(in_rdy), 64'd0);
    tick();
    chk("dom_count0", 64'(count), 64'd0);
    chk("dom_in_rdy_empty", 64'(in_rdy), 64'd1);
    chk("dom_out_domain_old", 64'(out_domain), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("dom_out_domain_new", 64'(out_domain), 64'd1);
    head("dom_h33", 32'h33, 56'h33);
    chk("dom_in_rdy_d0_mismatch", 64'(in_rdy), 64'd0);
    tick();
    chk("dom_drained_count", 64'(count), 64'd0);
    chk("dom_domain_kept", 64'(out_domain), 64'd1);
    out_rdy = 1'b0;

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 56'(32'h70 + i), 32'(32'h71 + i));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    chk("ar_count3", 64'(count), 64'd3);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_out_val", 64'(out_val), 64'd0);
    chk("ar_count0", 64'(count), 64'd0);
    chk("ar_out_domain", 64'(out_domain), 64'd0);
    chk("ar_data0", 64'(out_msg_data), 64'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 56'h9, 32'h99);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    head("ar_first_head", 32'h99, 56'h9);
    chk("ar_count1", 64'(count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
